// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED PWM fader.
// Module parameters default to these values and may be overridden per instance.
package led_pkg;

  localparam int unsigned N_LED    = 10;
  localparam int unsigned PWM_BITS = 8;
  localparam int unsigned PWM_MAX  = (1 << PWM_BITS) - 1;

  // Works at full int width so any PWM_BITS override can reuse it; callers truncate.
  function automatic int unsigned sat_sub(input int unsigned value, input int unsigned step);
    return (value > step) ? (value - step) : 32'd0;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness with decay, period-aligned shadow duty, registered compare.
module led_pwm_channel #(
  parameter int unsigned PWM_BITS   = led_pkg::PWM_BITS,
  parameter int unsigned DECAY_STEP = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                led_i,
  input  logic                decay_tick_i,
  input  logic                period_end_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o
);
  import led_pkg::*;

  localparam logic [PWM_BITS-1:0] PwmMax = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [PWM_BITS-1:0] active_q, active_d;
  logic [PWM_BITS-1:0] bright_dec;
  logic                led_q, led_d;

  assign bright_dec = PWM_BITS'(sat_sub(int'(bright_q), DECAY_STEP));

  always_comb begin
    bright_d = bright_q;
    active_d = active_q;
    led_d    = 1'b0;
    if (en_i) begin
      if (led_i) begin
        bright_d = PwmMax;
      end else if (decay_tick_i) begin
        bright_d = bright_dec;
      end
      // Shadow load sees the pre-update brightness when both land together.
      if (period_end_i) begin
        active_d = bright_q;
      end
      led_d = (active_q == PwmMax) || (pwm_cnt_i < active_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bright_q <= '0;
      active_q <= '0;
      led_q    <= 1'b0;
    end else begin
      bright_q <= bright_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pwm_fader.sv
// Per-channel PWM driver that fades each LED out after release (comet tail).
// Holds the shared PWM counter, decay prescaler and period-end strobe.
module led_pwm_fader #(
  parameter int unsigned N_LED      = led_pkg::N_LED,
  parameter int unsigned PWM_BITS   = led_pkg::PWM_BITS,
  parameter int unsigned DECAY_DIV  = 195312,
  parameter int unsigned DECAY_STEP = 32
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_LED-1:0] led_in,
  output logic [N_LED-1:0] led_out,
  output logic             pwm_period_end
);
  import led_pkg::*;

  localparam int unsigned         DivW    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DivW-1:0]     DivLast = DivW'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] PwmMax  = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [DivW-1:0]     div_q, div_d;
  logic                pe_q, pe_d;
  logic                period_end;
  logic                decay_tick;

  assign period_end = (cnt_q == PwmMax);
  assign decay_tick = (div_q == DivLast);

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    pe_d  = 1'b0;
    if (enable) begin
      cnt_d = cnt_q + 1'b1;
      div_d = decay_tick ? '0 : div_q + 1'b1;
      // Strobe is aligned with the cycle in which the counter shows PWM_MAX.
      pe_d  = (cnt_d == PwmMax);
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= '0;
      pe_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      pe_q  <= pe_d;
    end
  end

  assign pwm_period_end = pe_q;

  for (genvar i = 0; i < int'(N_LED); i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk_i       (clk_50M),
      .rst_i       (reset),
      .en_i        (enable),
      .led_i       (led_in[i]),
      .decay_tick_i(decay_tick),
      .period_end_i(period_end),
      .pwm_cnt_i   (cnt_q),
      .led_o       (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with a 4-bit PWM and fast decay.
module tb_led_pwm_fader;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] led_in;
  logic [9:0] led_out;
  logic       pwm_period_end;

  int checks = 0;
  int errors = 0;
  int pc     = 0;  // expected PWM counter value in the current cycle

  always #10 clk_50M = ~clk_50M;

  led_pwm_fader #(
    .N_LED     (10),
    .PWM_BITS  (4),
    .DECAY_DIV (4),
    .DECAY_STEP(4)
  ) dut (
    .clk_50M       (clk_50M),
    .reset         (reset),
    .enable        (enable),
    .led_in        (led_in),
    .led_out       (led_out),
    .pwm_period_end(pwm_period_end)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 2 ns after the rising edge.
  task automatic step();
    logic r, e;
    r = reset;
    e = enable;
    @(posedge clk_50M);
    #2;
    if (r) pc = 0;
    else if (e) pc = (pc + 1) % 16;
  endtask

  task automatic goto_cnt(input int target);
    int guard;
    guard = 0;
    while (pc != target && guard < 64) begin
      step();
      guard++;
    end
    if (pc != target) begin
      $display("FAIL goto_cnt: counter position %0d never reached", target);
      $fatal(1, "bench stalled");
    end
  endtask

  logic [9:0] exp_v;
  logic [9:0] acc;
  int         hi;

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    led_in = 10'h3FF;

    // 1: reset overrides enable and led_in
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_led", led_out, 10'h000);
      check("rst_pe", pwm_period_end, 1'b0);
    end
    reset  = 1'b0;
    led_in = 10'h000;
    goto_cnt(14);
    check("pe_before_end", pwm_period_end, 1'b0);
    step();
    check("pe_at_end", pwm_period_end, 1'b1);
    step();
    check("pe_after_end", pwm_period_end, 1'b0);

    // 2/3/4/6: one-cycle pulses at cnt 1,5,9,13 latch actives 3,7,11,15
    goto_cnt(1);  led_in = 10'h001; step(); led_in = 10'h000;
    goto_cnt(5);  led_in = 10'h002; step(); led_in = 10'h000;
    goto_cnt(9);  led_in = 10'h004; step(); led_in = 10'h000;
    goto_cnt(13); led_in = 10'h008; step(); led_in = 10'h000;
    goto_cnt(15);
    step();
    for (int k = 0; k < 16; k++) begin
      step();
      exp_v    = 10'h000;
      exp_v[0] = (k < 3);
      exp_v[1] = (k < 7);
      exp_v[2] = (k < 11);
      exp_v[3] = 1'b1;
      check("fade_period", led_out, exp_v);
    end
    // All channels have decayed to 0 by the next load; no wrap below zero
    acc = '0;
    for (int k = 0; k < 16; k++) begin
      step();
      acc = acc | led_out;
    end
    check("tail_zero", acc, 10'h000);

    // 5: led_in[3] held through the tick at cnt 11, released at cnt 12
    led_in = 10'h008;
    goto_cnt(12);
    led_in = 10'h000;
    goto_cnt(15);
    step();
    hi = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      check("reload_beats_decay", led_out, 10'h008);
    end

    // 7: freeze at cnt 9 for 7 cycles
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("dis_led", led_out, 10'h000);
      check("dis_pe", pwm_period_end, 1'b0);
    end
    enable = 1'b1;
    for (int k = 9; k < 16; k++) begin
      step();
      check("resume_led", led_out, 10'h008);
      check("resume_pe", pwm_period_end, (k == 14));
    end

    // 8: all channels full on, then reset pulsed at cnt 6
    led_in = 10'h3FF;
    goto_cnt(15);
    step();
    goto_cnt(6);
    check("pre_rst_led", led_out, 10'h3FF);
    reset = 1'b1;
    step();
    reset  = 1'b0;
    led_in = 10'h000;
    check("rst2_led", led_out, 10'h000);
    check("rst2_pe", pwm_period_end, 1'b0);
    acc = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      acc = acc | led_out;
      check("rst2_pe_seq", pwm_period_end, (k == 14));
    end
    check("rst2_cleared", acc, 10'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
